// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_pkg : shared constants and state encoding for the divider scheduler  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package div_pkg;

    localparam int DIV_WIDTH   = 12;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;

    localparam int ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_START   = 2'd1;
    localparam state_t S_RUN     = 2'd2;
    localparam state_t S_RELEASE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/div_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr (cyclic)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_k;

    // Scan from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        w_sum = '0;
        w_k   = '0;
        if (en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
                if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                    w_sum = w_sum - (IDX_W+1)'(N_REQ);
                end
                w_k = w_sum[IDX_W-1:0];
                if (req[w_k]) begin
                    grant      = '0;
                    grant[w_k] = 1'b1;
                    idx        = w_k;
                    valid      = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_scheduler : shares one divider among N_REQ requesters, round-robin.  |
// | Optional abort timer enabled by DIV_TIMEOUT_EN (adds err_timeout).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module div_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] dividend_i,
    input  logic [N_REQ*WIDTH-1:0] divisor_i,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       res_o,
    output logic [N_REQ-1:0]       res_valid,
    output logic                   res_div0,
    output logic                   div_en,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    input  logic [WIDTH-1:0]       div_res,
    input  logic                   div_busy,
    input  logic                   div_ready
`ifdef DIV_TIMEOUT_EN
    ,
    output logic                   err_timeout
`endif
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             div0_q, div0_d;

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_active;
    logic             w_done;
    logic             w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .en    (state_q == S_IDLE),
        .grant (w_grant),
        .idx   (w_idx),
        .valid (w_valid)
    );

    assign w_active = (state_q == S_START) || (state_q == S_RUN);
    assign w_done   = (state_q == S_RUN) && div_ready && !div_busy;

`ifdef DIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign w_timeout = w_active && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (w_active) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = w_timeout && !w_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            ack_q       <= '0;
            res_valid_q <= '0;
            res_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            div0_q      <= div0_d;
        end
    end

    // START only watches Busy so a sticky Ready from the last op is never taken as done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_valid) state_d = S_START;
            end
            S_START: begin
                if (w_timeout)     state_d = S_RELEASE;
                else if (div_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (w_done || w_timeout) state_d = S_RELEASE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        res_d       = res_q;
        div0_d      = div0_q;
        ack_d       = '0;
        res_valid_d = '0;
        div_en      = w_active;

        if ((state_q == S_IDLE) && w_valid) begin
            ack_d  = w_grant;
            gidx_d = w_idx;
            ptr_d  = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            for (int k = 0; k < N_REQ; k++) begin
                if (w_idx == IDX_W'(k)) begin
                    dvd_d = dividend_i[k*WIDTH +: WIDTH];
                    dvs_d = divisor_i[k*WIDTH +: WIDTH];
                end
            end
        end

        if (w_done) begin
            res_d       = (dvs_q == '0) ? '0 : div_res;
            div0_d      = (dvs_q == '0);
            res_valid_d = ONE_HOT0 << gidx_q;
        end else if (w_timeout) begin
            res_d       = '0;
            div0_d      = 1'b0;
            res_valid_d = ONE_HOT0 << gidx_q;
        end
    end

    assign ack          = ack_q;
    assign res_valid    = res_valid_q;
    assign res_o        = res_q;
    assign res_div0     = div0_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_scheduler : directed + random bench with a behavioural divider    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_div_scheduler;
    import div_pkg::*;

    localparam int W       = DIV_WIDTH;
    localparam int NR      = 4;
    localparam int DIV_LAT = 20;
`ifdef DIV_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req;
    logic [W-1:0]     a_v [NR];
    logic [W-1:0]     b_v [NR];
    logic [NR*W-1:0]  dividend_i, divisor_i;
    logic [NR-1:0]    ack, res_valid;
    logic [W-1:0]     res_o, div_dividend, div_divisor;
    logic             res_div0, div_en;
`ifdef DIV_TIMEOUT_EN
    logic             err_timeout;
`endif

    // behavioural divider: Busy for DIV_LAT cycles (2 for /0), sticky Ready,
    // no restart until en has dropped, abort when en drops while busy
    logic [W-1:0] dv_res   = '0;
    logic         dv_busy  = 1'b0;
    logic         dv_ready = 1'b0;
    logic         dv_wait  = 1'b0;
    int           dv_cnt   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            dividend_i[k*W +: W] = a_v[k];
            divisor_i[k*W +: W]  = b_v[k];
        end
    end

    always @(posedge clk) begin
        if (dv_busy) begin
            if (!div_en) begin
                dv_busy <= 1'b0;
                dv_wait <= 1'b0;
            end else if (dv_cnt <= 1) begin
                dv_busy  <= 1'b0;
                dv_ready <= 1'b1;
                dv_wait  <= 1'b1;
                dv_res   <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end else if (!div_en) begin
            dv_wait <= 1'b0;
        end else if (!dv_wait) begin
            dv_busy  <= 1'b1;
            dv_ready <= 1'b0;
            dv_cnt   <= (div_divisor == '0) ? 2 : DIV_LAT;
        end
    end

    div_scheduler #(
        .WIDTH   (W),
        .N_REQ   (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .ack          (ack),
        .res_o        (res_o),
        .res_valid    (res_valid),
        .res_div0     (res_div0),
        .div_en       (div_en),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_res      (dv_res),
        .div_busy     (dv_busy),
        .div_ready    (dv_ready)
`ifdef DIV_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [NR-1:0] hold;
    int            mptr;
    bit            infl;
    int            infl_g;
    logic [W-1:0]  exp_q;
    logic          exp_z;
    logic          exp_t;
    int            grant_log [$];
    int            inject_idx = -1;
    logic [W-1:0]  inj_a, inj_b;
    int            last_first_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: first pending requester at or after the pointer, cyclic
    function automatic int pick(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] s;
        for (int i = 0; i < NR; i++) begin
            s = r >> ((p + i) % NR);
            if (s[0]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic set_op(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
        a_v[k] = a;
        b_v[k] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
        infl = 1'b0;
        req  = '0;
    endtask

    task automatic run_ops(input int n);
        int         cyc, got, budget, g, first_ack, ack_cyc;
        bit         chk_next;
        logic [1:0] gi;
        cyc = 0; got = 0; chk_next = 1'b0; first_ack = -1; ack_cyc = 0;
        budget = n * (DIV_LAT + 12) + 20;
        while ((got < n || chk_next) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (chk_next) begin
                check("release_gap_ack", 32'(ack), 0);
                chk_next = 1'b0;
            end
            if (res_valid !== '0) begin
                check("rv_owner", 32'(res_valid), infl ? (32'd1 << infl_g) : 32'd0);
                check("res_o", 32'(res_o), 32'(exp_q));
                check("res_div0", 32'(res_div0), 32'(exp_z));
                check("div_en_release", 32'(div_en), 0);
                check("ack_rv_overlap", 32'(ack), 0);
`ifdef DIV_TIMEOUT_EN
                check("err_timeout", 32'(err_timeout), 32'(exp_t));
                if (exp_t) check("timeout_latency", cyc - ack_cyc, TMO);
`endif
                infl = 1'b0;
                got++;
                chk_next = 1'b1;
                if (got == n) begin
                    req  = '0;
                    hold = '0;
                end
            end
`ifdef DIV_TIMEOUT_EN
            else if (err_timeout !== 1'b0) begin
                check("err_timeout_stray", 32'(err_timeout), 0);
            end
`endif
            if (ack !== '0) begin
                g = pick(req, mptr);
                check("ack_grant", 32'(ack), (g < 0) ? 32'd0 : (32'd1 << g));
                check("single_in_flight", 32'(infl), 0);
                if (g >= 0) begin
                    gi      = 2'(g);
                    mptr    = (g + 1) % NR;
                    infl    = 1'b1;
                    infl_g  = g;
                    exp_z   = (b_v[gi] == '0);
                    exp_q   = exp_z ? '0 : a_v[gi] / b_v[gi];
                    exp_t   = 1'b0;
`ifdef DIV_TIMEOUT_EN
                    if (!exp_z) begin
                        exp_q = '0;
                        exp_t = 1'b1;
                    end
`endif
                    ack_cyc = cyc;
                    if (first_ack < 0) first_ack = cyc;
                    grant_log.push_back(g);
                    if (!hold[gi]) req = req & ~(NR'(1) << g);
                    if (inject_idx >= 0) begin
                        set_op(2'(inject_idx), inj_a, inj_b);
                        req = req | (NR'(1) << inject_idx);
                        inject_idx = -1;
                    end
                end
            end
        end
        check("ops_completed", got, n);
        last_first_ack = first_ack;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            n, rv_cnt;
        logic [NR-1:0] mask;
        req  = '0;
        hold = '0;
        mptr = 0;
        infl = 1'b0;
        for (int k = 0; k < NR; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_o", 32'(res_o), 0);
        check("rst_res_div0", 32'(res_div0), 0);
        check("rst_div_en", 32'(div_en), 0);
        check("rst_div_dividend", 32'(div_dividend), 0);
        check("rst_div_divisor", 32'(div_divisor), 0);
        rst = 1'b0;

        // single request, grant the cycle after req
        set_op(2'd0, 12'd100, 12'd7);
        req = 4'b0001;
        run_ops(1);
        check("t1_ack_latency", last_first_ack, 1);

        // three simultaneous requests from ptr 0
        do_reset();
        set_op(2'd0, 12'd100, 12'd7);
        set_op(2'd1, 12'd4095, 12'd1);
        set_op(2'd2, 12'd50, 12'd5);
        grant_log.delete();
        req = 4'b0111;
        run_ops(3);
        check("t2_order0", grant_log[0], 0);
        check("t2_order1", grant_log[1], 1);
        check("t2_order2", grant_log[2], 2);

        // divide by zero, then an op that must ignore the stale Ready
        set_op(2'd1, 12'd123, 12'd0);
        req = 4'b0010;
        run_ops(1);
        set_op(2'd1, 12'd9, 12'd3);
        req = 4'b0010;
        run_ops(1);

        // asynchronous reset in the middle of a division
        set_op(2'd1, 12'd200, 12'd3);
        req = 4'b0010;
        n = 0;
        while (ack === '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_ack_seen", 32'(ack), 32'h2);
        req = '0;
        repeat (5) @(negedge clk);
        check("t4_divider_busy", 32'(dv_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_ack", 32'(ack), 0);
        check("t4_rst_res_valid", 32'(res_valid), 0);
        check("t4_rst_res_o", 32'(res_o), 0);
        check("t4_rst_res_div0", 32'(res_div0), 0);
        check("t4_rst_div_en", 32'(div_en), 0);
        check("t4_rst_div_dividend", 32'(div_dividend), 0);
        check("t4_rst_div_divisor", 32'(div_divisor), 0);
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
        infl = 1'b0;
        rv_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid !== '0) rv_cnt++;
        end
        check("t4_no_stale_result", rv_cnt, 0);
        set_op(2'd2, 12'd81, 12'd9);
        req = 4'b0100;
        run_ops(1);

        // requester 3 held high, requester 0 joins during its op
        set_op(2'd3, 12'd3000, 12'd17);
        hold       = 4'b1000;
        inject_idx = 0;
        inj_a      = 12'd60;
        inj_b      = 12'd4;
        grant_log.delete();
        req = 4'b1000;
        run_ops(3);
        check("t5_order0", grant_log[0], 3);
        check("t5_order1", grant_log[1], 0);
        check("t5_order2", grant_log[2], 3);

        // random request masks and operands
        for (int r = 0; r < 10; r++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int k = 0; k < NR; k++) begin
                a_v[k] = W'($urandom_range(0, (1 << W) - 1));
                b_v[k] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
            end
            req = mask;
            run_ops($countones(mask));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
